// File: rtl/demux_1to2_fifo.sv
// One-to-two demultiplexer with a small FIFO per output channel; sel routes each word.
// Defining DEMUX_COUNT_EN adds per-channel delivered-word counters on cnt0/cnt1.

module demux_1to2_fifo_ch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             vld,
  output logic [WIDTH-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    occ_d = occ_q;
    if (push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end

  assign full  = (occ_q == (AW+1)'(DEPTH));
  assign vld   = (occ_q != '0);
  assign rdata = vld ? mem_q[rp_q] : '0;
endmodule

module demux_1to2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);
  logic full0, full1, push0, push1, pop0, pop1;

  // Ready depends only on sel and registered occupancy: a full FIFO never passes through.
  assign in_ready = sel ? ~full1 : ~full0;
  assign push0    = in_valid & in_ready & ~sel;
  assign push1    = in_valid & in_ready &  sel;
  assign pop0     = y0_valid & y0_ready;
  assign pop1     = y1_valid & y1_ready;

  demux_1to2_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .wdata(in_data), .pop(pop0),
    .full(full0), .vld(y0_valid), .rdata(y0_data)
  );

  demux_1to2_fifo_ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .wdata(in_data), .pop(pop1),
    .full(full1), .vld(y1_valid), .rdata(y1_data)
  );

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q + {15'd0, pop0};
    cnt1_d = cnt1_q + {15'd0, pop1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = 16'h0000;
  assign cnt1 = 16'h0000;
`endif
endmodule

// File: tb/tb_demux_1to2_fifo.sv
// Scoreboard bench for demux_1to2_fifo: accepted words are queued per channel and matched on delivery.
module tb_demux_1to2_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       sel, in_valid, in_ready;
  logic [7:0] y0_data, y1_data;
  logic       y0_valid, y1_valid, y0_ready, y1_ready;
  logic [15:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  int pops0 = 0;
  int pops1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  demux_1to2_fifo #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .y0_data(y0_data), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1_data(y1_data), .y1_valid(y1_valid), .y1_ready(y1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int p);
`ifdef DEMUX_COUNT_EN
    return p[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  // Transfers are judged at the falling edge; they take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (sel) q1.push_back(in_data);
        else     q0.push_back(in_data);
      end
      if (y0_valid && y0_ready) begin
        pops0++;
        if (q0.size() == 0) check("y0_extra", 1, 0);
        else                check("y0_data", y0_data, q0.pop_front());
      end
      if (y1_valid && y1_ready) begin
        pops1++;
        if (q1.size() == 0) check("y1_extra", 1, 0);
        else                check("y1_data", y1_data, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("drain_timeout", 1, 0);
  endtask

  initial begin
    int target;
    int n;
    rst_n = 1'b0; in_data = '0; sel = 1'b0; in_valid = 1'b0;
    y0_ready = 1'b0; y1_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_y0_valid", y0_valid, 0);
    check("rst_y1_valid", y1_valid, 0);
    check("rst_y0_data", y0_data, 0);
    check("rst_cnt0", cnt0, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // single word to y0, one-cycle latency
    sel = 1'b0; in_data = 8'hA5; in_valid = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a_y0_valid", y0_valid, 1);
    check("a_y0_data", y0_data, 8'hA5);
    check("a_y1_valid", y1_valid, 0);
    tick();
    check("a_y0_gone", y0_valid, 0);
    check("a_y0_data_zero", y0_data, 0);

    // fill y1 while stalled; y0 still accepts
    y1_ready = 1'b0; sel = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_valid = 1'b0;
    check("b_ready_sel1_full", in_ready, 0);
    sel = 1'b0;
    #1;
    check("b_ready_sel0", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    check("b_y1_stalled", y1_valid, 1);
    check("b_y1_head", y1_data, 8'h11);
    drain();

    // full y0 with same-cycle pop: push refused
    y0_ready = 1'b0; y1_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; in_data = 8'h41;
    tick();
    in_data = 8'h42;
    tick();
    in_data = 8'h43; y0_ready = 1'b1;
    check("c_full_refuse", in_ready, 0);
    tick();
    y0_ready = 1'b0;
    check("c_occ1_ready", in_ready, 1);
    check("c_occ1_head", y0_data, 8'h42);
    tick();
    in_valid = 1'b0;
    check("c_full_again", in_ready, 0);
    drain();

    // alternating channels
    for (int i = 1; i <= 8; i++) begin
      sel = (i % 2 == 0); in_data = 8'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain();

    // reset mid-operation drops queued words
    y0_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; in_data = 8'h51;
    tick();
    in_data = 8'h52;
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_rst_y0_valid", y0_valid, 0);
    check("e_rst_y0_data", y0_data, 0);
    check("e_rst_in_ready", in_ready, 1);
    q0.delete(); q1.delete(); pops0 = 0; pops1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    repeat (4) tick();
    check("e_no_stale_y0", y0_valid, 0);
    check("e_cnt0_zero", cnt0, 0);

    // delivered-word counter up to and across wrap
`ifdef DEMUX_COUNT_EN
    target = 65534;
`else
    target = 20;
`endif
    sel = 1'b0; in_valid = 1'b1; y0_ready = 1'b1; n = 0;
    while (pops0 < target && n < 70000) begin
      in_data = 8'(n);
      tick();
      n++;
    end
    if (n >= 70000) check("f_stream_timeout", 1, 0);
    in_valid = 1'b0; y0_ready = 1'b0;
    check("f_cnt0_pre", cnt0, exp_cnt(pops0));
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0; y0_ready = 1'b1;
    repeat (2) tick();
    y0_ready = 1'b0;
    check("f_cnt0_post", cnt0, exp_cnt(pops0));
`ifdef DEMUX_COUNT_EN
    check("f_cnt0_wrapped", cnt0, 16'h0000);
`endif
    check("f_cnt1", cnt1, exp_cnt(pops1));
    drain();
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_1to2_fifo.md
DEMUX_1TO2_FIFO -- requirements
Module: demux_1to2_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the input and of both output channels.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output FIFO (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_data  input  WIDTH  input word.
REQ-006 SHALL have port sel  input  1  destination: 0 selects y0, 1 selects y1; sampled with in_data.
REQ-007 SHALL have port in_valid  input  1  input word and sel are valid.
REQ-008 SHALL have port in_ready  output  1  block accepts the input word this cycle.
REQ-009 SHALL have ports y0_data / y1_data  output  WIDTH  head-of-FIFO word per channel.
REQ-010 SHALL have ports y0_valid / y1_valid  output  1  channel FIFO non-empty.
REQ-011 SHALL have ports y0_ready / y1_ready  input  1  downstream consumes head word.
REQ-012 SHALL have ports cnt0 / cnt1  output  16  per-channel delivered-word counters (see Configuration).

Function
REQ-013 SHALL perform an input transfer in a cycle where in_valid=1 and in_ready=1; the word is written to FIFO sel.
REQ-014 SHALL drive in_ready = NOT full(FIFO selected by current sel), combinationally from sel and registered occupancy only (no dependence on in_valid or yN_ready).
REQ-015 SHALL never write a word to the non-selected FIFO; that channel's state is unchanged by the transfer.
REQ-016 SHALL perform an output transfer on channel N in a cycle where yN_valid=1 and yN_ready=1; the head entry is removed.
REQ-017 SHALL present a word accepted at edge k on yN_data with yN_valid=1 after edge k if the FIFO was empty (one-cycle latency, no combinational in-to-out path).
REQ-018 SHALL preserve per-channel order; no ordering relation between channels is guaranteed or required.
REQ-019 SHALL hold yN_data stable while yN_valid=1 and yN_ready=0.
REQ-020 SHALL, on simultaneous push and pop to the same non-empty, non-full FIFO, keep occupancy unchanged and advance both pointers.
REQ-021 SHALL, when the selected FIFO is full, hold in_ready=0 even if a pop on that channel occurs the same cycle (no full-pass-through).
REQ-022 SHALL allow pushes to one channel while the other is full and stalled.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
REQ-024 SHALL drive yN_data to 0 when yN_valid=0.

Reset
REQ-025 SHALL, on rst_n=0, immediately clear both FIFOs (pointers and occupancy to 0), yN_valid=0, yN_data=0, cnt0=cnt1=0.
REQ-026 SHALL drop all in-flight words if reset asserts mid-operation; no word is delivered after reset release that was accepted before it.
REQ-027 SHALL drive in_ready=1 during reset and from the first cycle after release (both FIFOs empty).

Configuration
REQ-028 SHALL, with macro DEMUX_COUNT_EN defined, increment cntN by 1 on each output transfer of channel N, wrapping 16'hFFFF -> 16'h0000.
REQ-029 SHALL, with DEMUX_COUNT_EN undefined, tie cnt0 and cnt1 to 16'h0000 with no counter registers; all other behaviour identical.

Verification
REQ-030 SHALL cover: sel=0, in_data=8'hA5, in_valid=1 one cycle, y0_ready=1 -> y0_valid=1 with y0_data=8'hA5 next cycle for one cycle; y1_valid stays 0.
REQ-031 SHALL cover: y1_ready=0, push 8'h11,8'h22 to sel=1 -> in_ready=0 while sel=1, in_ready=1 when sel=0; then y1_ready=1 -> 8'h11 then 8'h22 in order.
REQ-032 SHALL cover: y0 FIFO full, same-cycle push (sel=0) and pop -> push refused (in_ready=0), occupancy drops to 1; next cycle push accepted.
REQ-033 SHALL cover: alternating sel 0/1 with 8'h01..8'h08, both readies 1 -> y0 gets 01,03,05,07; y1 gets 02,04,06,08.
REQ-034 SHALL cover: two words queued on y0, rst_n pulsed low mid-cycle -> y0_valid=0 immediately and neither word appears after release.
REQ-035 SHALL cover (DEMUX_COUNT_EN): cnt0 preloaded to 16'hFFFE via 2 pops short of wrap -> after 2 more y0 transfers cnt0=16'h0000; without macro cnt0 stays 0.
